shrg_seq_ctrl: RTL and testbench
================================

Name: shrg_seq_ctrl

Overview:
- Sequencer for the team's N-bit shift register. It drives the register's wri, shift and set controls.
- Two operating modes:
  - Parallel-load mode: wri for one cycle, then set.
  - Serial-capture mode: shift for a programmed bit count, gated by a data-enable stall input, then set.
- Provides a start/busy/done handshake and an abort path.
- Sits between a host or bus FSM and one shift register instance.

Parameters:
- N, 8, width of the controlled shift register; maximum serial bit count.
- CW, 4, bit-count width; must satisfy 2^CW > N.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- mode  in  1  0 = serial capture, 1 = parallel load; sampled with start.
- len  in  CW  serial bit count; sampled with start.
- data_en  in  1  serial bit available this cycle; stalls shifting when low.
- abort  in  1  cancel the current operation.
- shift_o  out  1  drives the register's shift input.
- wri_o  out  1  drives the register's wri input.
- set_o  out  1  drives the register's set input.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- cnt  out  CW  remaining serial bits.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - shift_o=wri_o=set_o=busy=done=0; cnt=0.
  - Takes effect immediately, mid-operation included.
  - Leaving reset: first active edge is the first posedge with reset=1.
- All outputs are Moore outputs decoded from registered state and cnt. No combinational path from any input to any output.
- States: IDLE, LOAD, SHIFT, COMMIT, DONE.
- IDLE:
  - start=1 with mode=1 -> LOAD.
  - start=1 with mode=0 -> SHIFT, cnt <= Leff.
  - Leff = N if len==0 or len>N; otherwise Leff = len.
- LOAD: wri_o=1 -> COMMIT unconditionally (1 cycle).
- SHIFT:
  - shift_o = data_en (gated combinationally from registered state AND data_en). This is the sole permitted input-to-output path.
  - On each edge with data_en=1: cnt <= cnt-1.
  - When cnt==1 and data_en=1 -> COMMIT, cnt <= 0.
  - data_en=0: hold state and cnt, shift_o=0.
- COMMIT: set_o=1 -> DONE (1 cycle).
- DONE: done=1 -> IDLE (1 cycle). busy is still high in DONE and drops entering IDLE.
- Mutual exclusion: at most one of wri_o, shift_o, set_o is high in any cycle.
- Latency, start sampled at edge 0:
  - Parallel load: register sees wri at edge 1 and set at edge 2; done high between edges 2 and 3.
  - Serial, no stalls: shifts at edges 1..L, set at edge L+1, done between edges L+1 and L+2.
  - Each stall cycle adds 1 to the serial latency.
- start while busy: ignored, no queuing. start in the DONE cycle is also ignored. The next start is accepted from IDLE.
- abort=1 at an edge in LOAD, SHIFT or COMMIT:
  - Next state is IDLE and cnt <= 0.
  - No set_o and no done pulse for the aborted operation.
  - abort in DONE or IDLE has no effect.
- Simultaneous abort and COMMIT: if abort=1 on the edge that would leave SHIFT for COMMIT, abort wins and set_o never asserts.
- reset wins over every input.

Test Plan:
- Parallel load, N=8: start=1, mode=1 at edge 0 -> wri_o high cycle 1, set_o high cycle 2, done high cycle 3, busy high cycles 1-3, IDLE in cycle 4.
- Serial capture, len=5, data_en=1 constant -> shift_o high cycles 1-5, cnt reads 5,4,3,2,1; set_o cycle 6; done cycle 7. With a real shrg attached and serial bits 1,0,1,1,0, its o becomes 8'bxxx10110 (low 5 bits) after set.
- Stalls: len=3, data_en pattern 1,0,0,1,1 -> exactly 3 shift_o pulses; cnt holds at 2 across both stall cycles; set_o in cycle 6.
- Clamp: len=0 and len=12 -> each performs exactly 8 shifts before set_o.
- Abort in SHIFT at cnt=2 -> IDLE next cycle; no set_o, no done. Also: start asserted in the same cycle as done -> ignored; the following start -> accepted.
- Async reset asserted mid-SHIFT, between clock edges -> all outputs 0 before the next edge. Release, then start -> normal parallel-load sequence.

Source files
------------

// File: rtl/shrg_seq_ctrl.sv
// Control sequencer for one N-bit shift register: parallel load (wri then set)
// or serial capture (data_en-gated shifts over a programmed count, then set).
module shrg_seq_ctrl #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [CW-1:0] len,
    input  logic          data_en,
    input  logic          abort,
    output logic          shift_o,
    output logic          wri_o,
    output logic          set_o,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SHIFT  = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [CW-1:0] N_CW = CW'(N);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt_nxt;

    // A zero or oversized length means a full-width capture.
    function automatic logic [CW-1:0] eff_len(input logic [CW-1:0] l);
        if (l == '0 || l > N_CW)
            return N_CW;
        return l;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    if (mode) begin
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = SHIFT;
                        cnt_nxt   = eff_len(len);
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = COMMIT;
                end
            end
            SHIFT: begin
                // Abort takes priority over the final shift's move to COMMIT.
                if (abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (data_en) begin
                    cnt_nxt = cnt - CW'(1);
                    if (cnt == CW'(1))
                        state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                if (abort) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        shift_o = 1'b0;
        wri_o   = 1'b0;
        set_o   = 1'b0;
        done    = 1'b0;
        busy    = (state != IDLE);
        case (state)
            LOAD:    wri_o   = 1'b1;
            SHIFT:   shift_o = data_en;
            COMMIT:  set_o   = 1'b1;
            DONE:    done    = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shrg_seq_ctrl.sv
// Directed bench for shrg_seq_ctrl: load, serial, stall, clamp, abort and
// async-reset sequences with hand-computed cycle-by-cycle expectations.
module tb_shrg_seq_ctrl;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          start;
    logic          mode;
    logic [CW-1:0] len;
    logic          data_en;
    logic          abort;
    logic          shift_o;
    logic          wri_o;
    logic          set_o;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;

    int checks = 0;
    int errors = 0;

    shrg_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .len     (len),
        .data_en (data_en),
        .abort   (abort),
        .shift_o (shift_o),
        .wri_o   (wri_o),
        .set_o   (set_o),
        .busy    (busy),
        .done    (done),
        .cnt     (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare {shift_o, wri_o, set_o, busy, done, cnt} after inputs settle.
    task automatic expo(input string tag, input logic sh, input logic wr, input logic se,
                        input logic bu, input logic dn, input logic [CW-1:0] cn);
        #1;
        chk(tag, 32'({shift_o, wri_o, set_o, busy, done, cnt}),
                 32'({sh, wr, se, bu, dn, cn}));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // At most one register control may be active in any cycle.
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            assert ((32'(shift_o) + 32'(wri_o) + 32'(set_o)) <= 1) else begin
                errors++;
                $error("FAIL mutex: observed sh/wr/se %b%b%b expected at most one high",
                       shift_o, wri_o, set_o);
            end
        end
    end

    logic [0:4] stall_pat;
    logic [3:0] stall_cnt [0:4];
    int         nshift;
    bit         seen_set;

    initial begin
        reset = 1'b0; start = 1'b0; mode = 1'b0; len = '0; data_en = 1'b0; abort = 1'b0;
        expo("reset_state", 0, 0, 0, 0, 0, 0);
        cyc(); cyc();
        reset = 1'b1;
        expo("idle_after_reset", 0, 0, 0, 0, 0, 0);

        // Parallel load
        start = 1'b1; mode = 1'b1;
        expo("pl_c0", 0, 0, 0, 0, 0, 0);
        cyc(); start = 1'b0;
        expo("pl_c1_wri", 0, 1, 0, 1, 0, 0);
        cyc(); expo("pl_c2_set", 0, 0, 1, 1, 0, 0);
        cyc(); expo("pl_c3_done", 0, 0, 0, 1, 1, 0);
        cyc(); expo("pl_c4_idle", 0, 0, 0, 0, 0, 0);

        // Serial capture, len=5, no stalls
        start = 1'b1; mode = 1'b0; len = 4'd5; data_en = 1'b1;
        expo("ser_c0", 0, 0, 0, 0, 0, 0);
        cyc(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expo($sformatf("ser_shift%0d", i + 1), 1, 0, 0, 1, 0, 4'(5 - i));
            cyc();
        end
        expo("ser_set", 0, 0, 1, 1, 0, 0);
        cyc(); expo("ser_done", 0, 0, 0, 1, 1, 0);
        cyc(); expo("ser_idle", 0, 0, 0, 0, 0, 0);

        // Stalls: len=3, data_en 1,0,0,1,1
        stall_pat = 5'b10011;
        stall_cnt[0] = 4'd3; stall_cnt[1] = 4'd2; stall_cnt[2] = 4'd2;
        stall_cnt[3] = 4'd2; stall_cnt[4] = 4'd1;
        start = 1'b1; mode = 1'b0; len = 4'd3;
        cyc(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_en = stall_pat[i];
            expo($sformatf("stall_c%0d", i + 1), stall_pat[i], 0, 0, 1, 0, stall_cnt[i]);
            cyc();
        end
        data_en = 1'b1;
        expo("stall_set_c6", 0, 0, 1, 1, 0, 0);
        cyc(); expo("stall_done_c7", 0, 0, 0, 1, 1, 0);
        cyc();

        // Length clamp: 0 and 12 both capture N bits
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; mode = 1'b0; len = (k == 0) ? 4'd0 : 4'd12; data_en = 1'b1;
            cyc(); start = 1'b0;
            #1 chk($sformatf("clamp%0d_cnt_init", k), 32'(cnt), 32'(N));
            nshift = 0; seen_set = 1'b0;
            for (int c = 0; c < 40 && !seen_set; c++) begin
                if (set_o) seen_set = 1'b1;
                else begin
                    if (shift_o) nshift++;
                    cyc();
                end
            end
            chk($sformatf("clamp%0d_set_seen", k), 32'(seen_set), 32'd1);
            chk($sformatf("clamp%0d_nshift", k), 32'(nshift), 32'(N));
            cyc(); cyc();
            expo($sformatf("clamp%0d_idle", k), 0, 0, 0, 0, 0, 0);
        end

        // Abort in SHIFT at cnt=2
        start = 1'b1; mode = 1'b0; len = 4'd5; data_en = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        abort = 1'b1;
        expo("abort_at_cnt2", 1, 0, 0, 1, 0, 2);
        cyc(); abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expo($sformatf("abort_quiet%0d", i), 0, 0, 0, 0, 0, 0);
            cyc();
        end

        // Abort on the final shift edge beats the move to COMMIT
        start = 1'b1; mode = 1'b0; len = 4'd1; data_en = 1'b1;
        cyc(); start = 1'b0; abort = 1'b1;
        expo("abort_last_shift", 1, 0, 0, 1, 0, 1);
        cyc(); abort = 1'b0;
        expo("abort_last_no_set", 0, 0, 0, 0, 0, 0);
        cyc(); expo("abort_last_no_done", 0, 0, 0, 0, 0, 0);

        // Abort during LOAD
        start = 1'b1; mode = 1'b1;
        cyc(); start = 1'b0; abort = 1'b1;
        expo("abort_load", 0, 1, 0, 1, 0, 0);
        cyc(); abort = 1'b0;
        expo("abort_load_idle", 0, 0, 0, 0, 0, 0);

        // Start during DONE is ignored; next start accepted
        start = 1'b1; mode = 1'b1;
        cyc(); start = 1'b0;
        cyc(); cyc();
        start = 1'b1;
        expo("done_with_start", 0, 0, 0, 1, 1, 0);
        cyc(); start = 1'b0;
        expo("start_in_done_ignored", 0, 0, 0, 0, 0, 0);
        start = 1'b1;
        cyc(); start = 1'b0;
        expo("next_start_accepted", 0, 1, 0, 1, 0, 0);
        cyc(); cyc(); cyc();

        // Async reset mid-SHIFT between edges
        start = 1'b1; mode = 1'b0; len = 4'd5; data_en = 1'b1;
        cyc(); start = 1'b0;
        cyc();
        expo("pre_reset_shift", 1, 0, 0, 1, 0, 4);
        reset = 1'b0;
        expo("async_reset_now", 0, 0, 0, 0, 0, 0);
        cyc();
        reset = 1'b1;
        start = 1'b1; mode = 1'b1;
        expo("post_reset_idle", 0, 0, 0, 0, 0, 0);
        cyc(); start = 1'b0;
        expo("post_reset_wri", 0, 1, 0, 1, 0, 0);
        cyc(); expo("post_reset_set", 0, 0, 1, 1, 0, 0);
        cyc(); expo("post_reset_done", 0, 0, 0, 1, 1, 0);
        cyc(); expo("post_reset_idle2", 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
